// File: rtl/rtc_time_counter.sv
// BCD time-of-day counter fed by a synchronized, edge-detected 1 Hz tick, with STOP/RUN control, time load and alarm.
// Latency: tick -> time SYNC_STAGES+1 cycles, load/start/stop 1 cycle; load_ready drops in RUN so the load source must hold.
module rtc_time_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rstn,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic       load_err,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       sec_pulse,
  output logic       day_wrap,
  output logic       alarm_hit,
  output logic       running
);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   tick_prev_q, tick_prev_d;
  logic                   tick_rise_q, tick_rise_d;
  logic [7:0]             hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic                   sec_pulse_q, sec_pulse_d;
  logic                   day_wrap_q, day_wrap_d;
  logic                   alarm_hit_q, alarm_hit_d;
  logic                   load_err_q, load_err_d;
  logic                   count_en, load_xfer, load_ok, alarm_ok, time_upd;

  // With both digits <= 9, an unsigned compare of the packed byte orders BCD values numerically.
  function automatic logic bcd_le(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], tick_in};
    tick_prev_d = sync_q[SYNC_STAGES-1];
    tick_rise_d = sync_q[SYNC_STAGES-1] & ~tick_prev_q;

    count_en  = tick_rise_q && (state_q == ST_RUN);
    load_xfer = load_valid && (state_q == ST_STOP);
    load_ok   = bcd_le(load_hh, 8'h23) && bcd_le(load_mm, 8'h59) && bcd_le(load_ss, 8'h59);
    alarm_ok  = bcd_le(alarm_hh, 8'h23) && bcd_le(alarm_mm, 8'h59);

    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (count_en) begin
      if (sec_q == 8'h59) begin
        sec_d = 8'h00;
        if (min_q == 8'h59) begin
          min_d  = 8'h00;
          hour_d = (hour_q == 8'h23) ? 8'h00 : bcd_inc(hour_q);
        end else begin
          min_d = bcd_inc(min_q);
        end
      end else begin
        sec_d = bcd_inc(sec_q);
      end
    end else if (load_xfer && load_ok) begin
      hour_d = load_hh;
      min_d  = load_mm;
      sec_d  = load_ss;
    end

    time_upd    = count_en || (load_xfer && load_ok);
    sec_pulse_d = count_en;
    day_wrap_d  = count_en && ({hour_q, min_q, sec_q} == 24'h235959);
    load_err_d  = load_xfer && !load_ok;
    // Only a fresh time can match, so holding still in STOP never re-fires the alarm.
    alarm_hit_d = time_upd && alarm_en && alarm_ok &&
                  ({hour_d, min_d, sec_d} == {alarm_hh, alarm_mm, 8'h00});

    state_d = state_q;
    if (stop)       state_d = ST_STOP;
    else if (start) state_d = ST_RUN;
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_STOP;
      sync_q      <= '0;
      tick_prev_q <= 1'b0;
      tick_rise_q <= 1'b0;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tick_prev_q <= tick_prev_d;
      tick_rise_q <= tick_rise_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      sec_pulse_q <= sec_pulse_d;
      day_wrap_q  <= day_wrap_d;
      alarm_hit_q <= alarm_hit_d;
      load_err_q  <= load_err_d;
    end
  end

  assign hour_bcd   = hour_q;
  assign min_bcd    = min_q;
  assign sec_bcd    = sec_q;
  assign sec_pulse  = sec_pulse_q;
  assign day_wrap   = day_wrap_q;
  assign alarm_hit  = alarm_hit_q;
  assign load_err   = load_err_q;
  assign running    = (state_q == ST_RUN);
  assign load_ready = (state_q == ST_STOP);

endmodule

// File: tb/tb_rtc_time_counter.sv
// Bench for rtc_time_counter: directed corner sequences, a load-vector table, and random traffic
// checked each cycle against a seconds-of-day reference model.
module tb_rtc_time_counter;
  localparam int S = 2;

  logic       sys_clk = 1'b0;
  logic       rstn = 1'b1;
  logic       tick_in = 1'b0, start = 1'b0, stop = 1'b0, load_valid = 1'b0, alarm_en = 1'b0;
  logic [7:0] load_hh = 8'h00, load_mm = 8'h00, load_ss = 8'h00;
  logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
  logic       load_ready, load_err, sec_pulse, day_wrap, alarm_hit, running;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;

  rtc_time_counter #(.SYNC_STAGES(S)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .tick_in(tick_in), .start(start), .stop(stop),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_err(load_err),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .sec_pulse(sec_pulse), .day_wrap(day_wrap), .alarm_hit(alarm_hit), .running(running)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0, n_fail = 0;
  int sp_cnt = 0, dw_cnt = 0, ah_cnt = 0;

  // Reference model: time as seconds since midnight, a delay line of sampled tick_in values, run flag.
  int m_t = 0;
  bit m_run = 1'b0;
  bit dq[$];
  bit e_sp, e_dw, e_ah, e_le;

  function automatic int dec(input logic [7:0] v, input int lim);
    int val;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
    val = int'(v[7:4]) * 10 + int'(v[3:0]);
    return (val > lim) ? -1 : val;
  endfunction

  function automatic logic [7:0] enc(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] enc_t(input int t);
    return {enc(t / 3600), enc((t / 60) % 60), enc(t % 60)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_run = 1'b0;
    dq.delete();
    repeat (S + 2) dq.push_back(1'b0);
  endtask

  // One sys_clk edge: predict from the inputs now applied, then compare every output after the edge.
  task automatic cycle();
    int lh, lm, ls, ah, am;
    bit rise, cnt, xfer, ok, upd;
    rise = dq[1] && !dq[0];
    cnt  = rise && m_run;
    xfer = load_valid && !m_run;
    lh = dec(load_hh, 23); lm = dec(load_mm, 59); ls = dec(load_ss, 59);
    ok = (lh >= 0) && (lm >= 0) && (ls >= 0);
    e_sp = cnt;
    e_dw = cnt && (m_t == 86399);
    e_le = xfer && !ok;
    upd  = cnt || (xfer && ok);
    if (cnt) m_t = (m_t + 1) % 86400;
    else if (xfer && ok) m_t = lh * 3600 + lm * 60 + ls;
    ah = dec(alarm_hh, 23); am = dec(alarm_mm, 59);
    e_ah = upd && alarm_en && (ah >= 0) && (am >= 0) && (m_t == ah * 3600 + am * 60);
    if (stop) m_run = 1'b0;
    else if (start) m_run = 1'b1;
    void'(dq.pop_front());
    dq.push_back(bit'(tick_in));
    @(posedge sys_clk);
    #1;
    check("time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'(enc_t(m_t)));
    check("pulses", 32'({sec_pulse, day_wrap, alarm_hit, load_err}), 32'({e_sp, e_dw, e_ah, e_le}));
    check("state", 32'({running, load_ready}), 32'({m_run, !m_run}));
    sp_cnt += int'(sec_pulse);
    dw_cnt += int'(day_wrap);
    ah_cnt += int'(alarm_hit);
  endtask

  // Asserts reset between edges, checks the outputs clear at once, releases mid-cycle.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    check("reset_outputs",
          32'({hour_bcd, min_bcd, sec_bcd, sec_pulse, day_wrap, alarm_hit, load_err, running, load_ready}),
          32'({24'h000000, 4'b0000, 1'b0, 1'b1}));
    model_reset();
    @(posedge sys_clk);
    @(posedge sys_clk);
    #3 rstn = 1'b1;
  endtask

  // One full tick_in period at minimum legal high/low time; lat is the cycle offset of sec_pulse.
  task automatic tick(input int stop_at, output int lat);
    lat = -1;
    for (int j = 0; j < 2 * (S + 1); j++) begin
      tick_in = (j < S + 1);
      stop = (j == stop_at);
      cycle();
      if (sec_pulse && lat < 0) lat = j;
    end
    stop = 1'b0;
  endtask

  task automatic apply_load(input logic [23:0] t, input logic with_start);
    {load_hh, load_mm, load_ss} = t;
    load_valid = 1'b1;
    start = with_start;
    cycle();
    load_valid = 1'b0;
    start = 1'b0;
  endtask

  typedef struct {
    logic [23:0] t;
    logic        err;
    logic [23:0] exp_t;
  } load_vec_t;

  load_vec_t vecs[8];

  initial begin
    int lat, sp0, ah0, tleft, ra_h, ra_m, lt;

    vecs[0] = '{24'h240000, 1'b1, 24'h000000};
    vecs[1] = '{24'h123A00, 1'b1, 24'h000000};
    vecs[2] = '{24'h123456, 1'b0, 24'h123456};
    vecs[3] = '{24'h006000, 1'b1, 24'h123456};
    vecs[4] = '{24'h00005A, 1'b1, 24'h123456};
    vecs[5] = '{24'h1A0000, 1'b1, 24'h123456};
    vecs[6] = '{24'h235959, 1'b0, 24'h235959};
    vecs[7] = '{24'h090909, 1'b0, 24'h090909};

    model_reset();
    do_reset();

    // Start, then three ticks with their latency.
    start = 1'b1; cycle(); start = 1'b0;
    sp0 = sp_cnt;
    for (int k = 0; k < 3; k++) begin
      tick(-1, lat);
      check("tick_latency", 32'(lat), 32'(S + 1));
    end
    check("three_ticks_sec", 32'(sec_bcd), 32'h03);
    check("three_ticks_pulses", 32'(sp_cnt - sp0), 32'd3);

    // Day wrap from 23:59:58, loaded together with start.
    stop = 1'b1; cycle(); stop = 1'b0;
    apply_load(24'h235958, 1'b1);
    check("load_start_running", 32'(running), 32'd1);
    sp0 = dw_cnt;
    tick(-1, lat);
    check("pre_wrap_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h235959);
    check("pre_wrap_no_dw", 32'(dw_cnt - sp0), 32'd0);
    tick(-1, lat);
    check("wrap_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h000000);
    check("wrap_dw_once", 32'(dw_cnt - sp0), 32'd1);

    // Load vector table applied in STOP.
    stop = 1'b1; cycle(); stop = 1'b0;
    foreach (vecs[i]) begin
      apply_load(vecs[i].t, 1'b0);
      check("tbl_err", 32'(load_err), 32'(vecs[i].err));
      check("tbl_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'(vecs[i].exp_t));
      cycle();
      check("tbl_err_single", 32'(load_err), 32'd0);
    end

    // Held load while running is not accepted.
    start = 1'b1; cycle(); start = 1'b0;
    {load_hh, load_mm, load_ss} = 24'h010203;
    load_valid = 1'b1;
    repeat (4) begin
      cycle();
      check("run_not_ready", 32'(load_ready), 32'd0);
      check("run_hold_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h090909);
    end
    load_valid = 1'b0;
    stop = 1'b1; cycle(); stop = 1'b0;

    // Alarm at 07:00 reached by one tick, then held in STOP.
    alarm_en = 1'b1; alarm_hh = 8'h07; alarm_mm = 8'h00;
    ah0 = ah_cnt;
    apply_load(24'h065959, 1'b1);
    tick(-1, lat);
    check("alarm_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h070000);
    check("alarm_hit_once", 32'(ah_cnt - ah0), 32'd1);
    stop = 1'b1; cycle(); stop = 1'b0;
    repeat (10) cycle();
    check("alarm_no_refire", 32'(ah_cnt - ah0), 32'd1);
    alarm_en = 1'b0;

    // Ticks in STOP dropped; start+stop together stays STOP; tick coincident with stop counted once.
    sp0 = sp_cnt;
    tick(-1, lat);
    tick(-1, lat);
    check("stop_drops_ticks", 32'(sp_cnt - sp0), 32'd0);
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    check("start_stop_same", 32'(running), 32'd0);
    start = 1'b1; cycle(); start = 1'b0;
    tick(S + 1, lat);
    check("tick_with_stop_count", 32'(sp_cnt - sp0), 32'd1);
    check("tick_with_stop_state", 32'(running), 32'd0);
    check("tick_with_stop_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h070001);
    tick(-1, lat);
    check("after_stop_dropped", 32'(sp_cnt - sp0), 32'd1);

    // Reset in RUN at 10:20:30, released with tick_in high.
    apply_load(24'h102030, 1'b1);
    check("pre_reset_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h102030);
    tick_in = 1'b1;
    do_reset();
    sp0 = sp_cnt;
    repeat (8) cycle();
    check("post_reset_no_pulse", 32'(sp_cnt - sp0), 32'd0);
    check("post_reset_stop", 32'(running), 32'd0);

    // Random traffic against the model.
    tleft = S + 1;
    ra_h = 0; ra_m = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        ra_h = int'($urandom_range(0, 23));
        ra_m = int'($urandom_range(0, 59));
        alarm_hh = enc(ra_h);
        alarm_mm = ($urandom_range(0, 7) == 0) ? 8'h6A : enc(ra_m);
        alarm_en = ($urandom_range(0, 3) != 0);
      end
      if (tleft == 0) begin
        tick_in = ~tick_in;
        tleft = int'($urandom_range(S + 1, S + 4));
      end
      tleft--;
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 9) == 0);
      load_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: begin
          load_hh = 8'($urandom); load_mm = 8'($urandom); load_ss = 8'($urandom);
        end
        1: begin
          lt = int'($urandom_range(0, 86399));
          {load_hh, load_mm, load_ss} = enc_t(lt);
        end
        2: begin
          lt = (ra_h * 3600 + ra_m * 60 + 86399) % 86400;
          {load_hh, load_mm, load_ss} = enc_t(lt);
        end
        default: begin
          {load_hh, load_mm, load_ss} = enc_t(ra_h * 3600 + ra_m * 60);
        end
      endcase
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
